// File: rtl/ram_cmd_arb_pkg.sv
// ram_cmd_arb_pkg: shared constants and helpers for the ram_cmd_arb slice
package ram_cmd_arb_pkg;
    localparam int MAX_PORTS = 16;
    localparam int STAT_WIDTH = 32;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ram_cmd_arb_tag_fifo.sv
// ram_cmd_arb_tag_fifo: synchronous FIFO of port indices for outstanding read beats
module ram_cmd_arb_tag_fifo #(
    parameter int DEPTH = 32,
    parameter int W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = level == LW'(DEPTH);
    assign empty = level == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rp];
    // storage array, no reset needed since level gates every read
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
            if (do_pop) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/ram_cmd_arb.sv
// ram_cmd_arb: round-robin N-port RAM command arbiter with burst lock and tagged read return (optional RAM_CMD_ARB_STATS_EN adds stat_beats)
module ram_cmd_arb
    import ram_cmd_arb_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH = 8,
    parameter int INTERLEAVE = 0,
    parameter int MAX_BURST = 16,
    parameter int TAG_DEPTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORTS*ID_WIDTH-1:0]         s_cmd_id,
    input  logic [PORTS*ADDR_WIDTH-1:0]       s_cmd_addr,
    input  logic [PORTS*DATA_WIDTH-1:0]       s_cmd_wr_data,
    input  logic [PORTS*STRB_WIDTH-1:0]       s_cmd_wr_strb,
    input  logic [PORTS-1:0]                  s_cmd_wr_en,
    input  logic [PORTS-1:0]                  s_cmd_rd_en,
    input  logic [PORTS-1:0]                  s_cmd_last,
    output logic [PORTS-1:0]                  s_cmd_ready,
    output logic [PORTS*ID_WIDTH-1:0]         s_rd_resp_id,
    output logic [PORTS*DATA_WIDTH-1:0]       s_rd_resp_data,
    output logic [PORTS-1:0]                  s_rd_resp_last,
    output logic [PORTS-1:0]                  s_rd_resp_valid,
    input  logic [PORTS-1:0]                  s_rd_resp_ready,
    output logic [ID_WIDTH-1:0]               m_cmd_id,
    output logic [ADDR_WIDTH-1:0]             m_cmd_addr,
    output logic [DATA_WIDTH-1:0]             m_cmd_wr_data,
    output logic [STRB_WIDTH-1:0]             m_cmd_wr_strb,
    output logic                              m_cmd_last,
    output logic                              m_cmd_wr_en,
    output logic                              m_cmd_rd_en,
    input  logic                              m_cmd_ready,
    input  logic [ID_WIDTH-1:0]               m_rd_resp_id,
    input  logic [DATA_WIDTH-1:0]             m_rd_resp_data,
    input  logic                              m_rd_resp_last,
    input  logic                              m_rd_resp_valid,
    output logic                              m_rd_resp_ready,
    output logic [$clog2(TAG_DEPTH+1)-1:0]    tag_level,
`ifdef RAM_CMD_ARB_STATS_EN
    output logic [PORTS*STAT_WIDTH-1:0]       stat_beats,
`endif
    output logic                              resp_underflow
);
    localparam int IW = idx_width(PORTS);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    if (PORTS < 2 || PORTS > MAX_PORTS) begin : g_bad_ports
        $error("ram_cmd_arb: PORTS out of range");
    end
    logic [PORTS-1:0] req, is_rd, elig;
    logic [IW-1:0] ptr, lock_port, gidx, gsel, head;
    logic lock, graw, gv, xfer, push, pop, full, empty, cap_hit, unlock;
    logic [CW-1:0] cnt;
    logic [CW:0] cnt_inc;
    assign req = s_cmd_wr_en | s_cmd_rd_en;
    assign is_rd = s_cmd_rd_en & ~s_cmd_wr_en;
    assign elig = req & ~(is_rd & {PORTS{full}});
    // pick the locked port, else the first eligible port at or after ptr
    always_comb begin
        graw = 1'b0;
        gidx = '0;
        if (lock) begin
            graw = elig[lock_port];
            gidx = lock_port;
        end else begin
            for (int k = PORTS - 1; k >= 0; k--) begin
                if (elig[(int'(ptr) + k) % PORTS]) begin
                    graw = 1'b1;
                    gidx = IW'((int'(ptr) + k) % PORTS);
                end
            end
        end
    end
    assign gv = graw & ~rst;
    assign xfer = gv & m_cmd_ready;
    assign gsel = gv ? gidx : '0;
    assign m_cmd_id = s_cmd_id[gsel*ID_WIDTH +: ID_WIDTH];
    assign m_cmd_addr = s_cmd_addr[gsel*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_cmd_wr_data = s_cmd_wr_data[gsel*DATA_WIDTH +: DATA_WIDTH];
    assign m_cmd_wr_strb = s_cmd_wr_strb[gsel*STRB_WIDTH +: STRB_WIDTH];
    assign m_cmd_last = s_cmd_last[gsel];
    assign m_cmd_wr_en = gv & s_cmd_wr_en[gsel];
    assign m_cmd_rd_en = gv & ~s_cmd_wr_en[gsel];
    assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);
    assign cap_hit = (MAX_BURST != 0) && (cnt_inc == (CW + 1)'(MAX_BURST));
    assign unlock = m_cmd_last | cap_hit;
    // advance the pointer and manage the burst lock on each transferred beat
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            lock <= 1'b0;
            lock_port <= '0;
            cnt <= '0;
        end else if (xfer) begin
            ptr <= (gidx == IW'(PORTS - 1)) ? '0 : gidx + IW'(1);
            if (INTERLEAVE == 0 && !unlock) begin
                lock <= 1'b1;
                lock_port <= gidx;
                cnt <= cnt_inc[CW-1:0];
            end else begin
                lock <= 1'b0;
                cnt <= '0;
            end
        end
    end
    assign push = xfer & is_rd[gidx];
    assign pop = m_rd_resp_valid & m_rd_resp_ready;
    ram_cmd_arb_tag_fifo #(.DEPTH(TAG_DEPTH), .W(IW)) u_tags (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(gidx),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .level(tag_level)
    );
    assign m_rd_resp_ready = ~rst & ~empty & s_rd_resp_ready[head];
    assign s_rd_resp_id = {PORTS{m_rd_resp_id}};
    assign s_rd_resp_data = {PORTS{m_rd_resp_data}};
    assign s_rd_resp_last = {PORTS{m_rd_resp_last}};
    for (genvar i = 0; i < PORTS; i++) begin : g_port
        assign s_cmd_ready[i] = xfer && gidx == IW'(i);
        assign s_rd_resp_valid[i] = ~rst & m_rd_resp_valid & ~empty & (head == IW'(i));
    end
    // sticky flag for a response that has no outstanding tag
    always_ff @(posedge clk) begin
        if (rst) resp_underflow <= 1'b0;
        else if (m_rd_resp_valid && empty) resp_underflow <= 1'b1;
    end
`ifdef RAM_CMD_ARB_STATS_EN
    for (genvar i = 0; i < PORTS; i++) begin : g_stat
        logic [STAT_WIDTH-1:0] beats;
        // saturating count of beats transferred for this port
        always_ff @(posedge clk) begin
            if (rst) beats <= '0;
            else if (s_cmd_ready[i] && ~&beats) beats <= beats + STAT_WIDTH'(1);
        end
        assign stat_beats[i*STAT_WIDTH +: STAT_WIDTH] = beats;
    end
`endif
endmodule

// File: tb/tb_ram_cmd_arb.sv
// tb_ram_cmd_arb: directed checks of arbitration, burst lock, tag routing and underflow
module tb_ram_cmd_arb;
    localparam int P = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int IDW = 8;
    logic clk = 1'b0;
    logic rst;
    logic [P*IDW-1:0] s_cmd_id;
    logic [P*AW-1:0] s_cmd_addr;
    logic [P*DW-1:0] s_cmd_wr_data;
    logic [P*SW-1:0] s_cmd_wr_strb;
    logic [P-1:0] s_cmd_wr_en, s_cmd_rd_en, s_cmd_last, s_cmd_ready;
    logic [P*IDW-1:0] s_rd_resp_id;
    logic [P*DW-1:0] s_rd_resp_data;
    logic [P-1:0] s_rd_resp_last, s_rd_resp_valid, s_rd_resp_ready;
    logic [IDW-1:0] m_cmd_id, m_rd_resp_id;
    logic [AW-1:0] m_cmd_addr;
    logic [DW-1:0] m_cmd_wr_data, m_rd_resp_data;
    logic [SW-1:0] m_cmd_wr_strb;
    logic m_cmd_last, m_cmd_wr_en, m_cmd_rd_en, m_cmd_ready;
    logic m_rd_resp_last, m_rd_resp_valid, m_rd_resp_ready;
    logic [2:0] tag_level;
    logic resp_underflow;
    int checks = 0;
    int errors = 0;
    int seq3 [12] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 0};

    ram_cmd_arb #(
        .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IDW),
        .INTERLEAVE(0), .MAX_BURST(4), .TAG_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_cmd_id(s_cmd_id), .s_cmd_addr(s_cmd_addr), .s_cmd_wr_data(s_cmd_wr_data),
        .s_cmd_wr_strb(s_cmd_wr_strb), .s_cmd_wr_en(s_cmd_wr_en), .s_cmd_rd_en(s_cmd_rd_en),
        .s_cmd_last(s_cmd_last), .s_cmd_ready(s_cmd_ready),
        .s_rd_resp_id(s_rd_resp_id), .s_rd_resp_data(s_rd_resp_data), .s_rd_resp_last(s_rd_resp_last),
        .s_rd_resp_valid(s_rd_resp_valid), .s_rd_resp_ready(s_rd_resp_ready),
        .m_cmd_id(m_cmd_id), .m_cmd_addr(m_cmd_addr), .m_cmd_wr_data(m_cmd_wr_data),
        .m_cmd_wr_strb(m_cmd_wr_strb), .m_cmd_last(m_cmd_last), .m_cmd_wr_en(m_cmd_wr_en),
        .m_cmd_rd_en(m_cmd_rd_en), .m_cmd_ready(m_cmd_ready),
        .m_rd_resp_id(m_rd_resp_id), .m_rd_resp_data(m_rd_resp_data), .m_rd_resp_last(m_rd_resp_last),
        .m_rd_resp_valid(m_rd_resp_valid), .m_rd_resp_ready(m_rd_resp_ready),
        .tag_level(tag_level), .resp_underflow(resp_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_cmd_wr_en = '0;
        s_cmd_rd_en = '0;
        s_cmd_last = '0;
    endtask

    task automatic drive(input int p, input logic wr, input logic rd, input logic last);
        s_cmd_wr_en[p] = wr;
        s_cmd_rd_en[p] = rd;
        s_cmd_last[p] = last;
    endtask

    initial begin
        int b0;
        b0 = 0;
        rst = 1'b1;
        idle();
        for (int p = 0; p < P; p++) begin
            s_cmd_id[p*IDW +: IDW] = IDW'(8'h10 + p);
            s_cmd_addr[p*AW +: AW] = AW'(16'h100 + p);
            s_cmd_wr_data[p*DW +: DW] = DW'(32'hD000_0000 + p);
            s_cmd_wr_strb[p*SW +: SW] = 4'hF;
            drive(p, 1'b1, 1'b0, 1'b1);
        end
        m_cmd_ready = 1'b1;
        m_rd_resp_valid = 1'b1;
        m_rd_resp_id = 8'h55;
        m_rd_resp_data = 32'hAAAA_0000;
        m_rd_resp_last = 1'b1;
        s_rd_resp_ready = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", s_cmd_ready, 0);
        chk("rst_wr_en", m_cmd_wr_en, 0);
        chk("rst_resp_ready", m_rd_resp_ready, 0);
        chk("rst_resp_valid", s_rd_resp_valid, 0);
        chk("rst_level", tag_level, 0);
        chk("rst_uflow", resp_underflow, 0);
        // stalled RAM: grant visible, no transfer
        @(negedge clk);
        rst = 1'b0;
        m_rd_resp_valid = 1'b0;
        m_cmd_ready = 1'b0;
        #1;
        chk("stall_ready", s_cmd_ready, 0);
        chk("stall_wr_en", m_cmd_wr_en, 1);
        chk("stall_addr", m_cmd_addr, 16'h100);
        // all ports single-beat writes: round robin 0,1,2,3,0,1
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m_cmd_ready = 1'b1;
            #1;
            chk("rr_ready", s_cmd_ready, 64'(4'b1 << (c % 4)));
            chk("rr_addr", m_cmd_addr, 64'(16'h100 + c % 4));
        end
        chk("rr_data", m_cmd_wr_data, 32'hD000_0001);
        // burst lock on port2 with a gap, port3 waiting
        @(negedge clk);
        idle();
        drive(2, 1'b1, 1'b0, 1'b0);
        drive(3, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lock_first", s_cmd_ready, 4'b0100);
        chk("lock_first_last", m_cmd_last, 0);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lock_gap", s_cmd_ready, 0);
        chk("lock_gap_en", m_cmd_wr_en, 0);
        chk("nogrant_addr", m_cmd_addr, 16'h100);
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lock_mid", s_cmd_ready, 4'b0100);
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 1'b1);
        #1;
        chk("lock_last", s_cmd_ready, 4'b0100);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lock_release", s_cmd_ready, 4'b1000);
        // port0 10-beat burst against port3 with a 4-beat cap
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            idle();
            drive(0, b0 < 10, 1'b0, b0 == 9);
            drive(3, 1'b1, 1'b0, 1'b1);
            #1;
            chk("burst_cap", s_cmd_ready, 64'(4'b1 << seq3[c]));
            if (seq3[c] == 0) b0++;
        end
        // reads from ports 0 and 2, responses routed back in order
        @(negedge clk);
        idle();
        drive(0, 1'b0, 1'b1, 1'b1);
        drive(2, 1'b0, 1'b1, 1'b1);
        #1;
        chk("rd_grant2", s_cmd_ready, 4'b0100);
        chk("rd_en", m_cmd_rd_en, 1);
        chk("rd_wr_en", m_cmd_wr_en, 0);
        chk("rd_id", m_cmd_id, 8'h12);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 1'b0);
        m_rd_resp_valid = 1'b1;
        m_rd_resp_data = 32'hAAAA_0002;
        #1;
        chk("rd_level1", tag_level, 1);
        chk("rd_grant0", s_cmd_ready, 4'b0001);
        chk("resp_route2", s_rd_resp_valid, 4'b0100);
        chk("resp_ready2", m_rd_resp_ready, 1);
        chk("resp_data2", s_rd_resp_data[2*DW +: DW], 32'hAAAA_0002);
        @(negedge clk);
        idle();
        m_rd_resp_data = 32'hAAAA_0000;
        s_rd_resp_ready = 4'b1110;
        #1;
        chk("pushpop_level", tag_level, 1);
        chk("resp_route0", s_rd_resp_valid, 4'b0001);
        chk("resp_backpressure", m_rd_resp_ready, 0);
        @(negedge clk);
        s_rd_resp_ready = '1;
        #1;
        chk("resp_ready0", m_rd_resp_ready, 1);
        @(negedge clk);
        m_rd_resp_valid = 1'b0;
        #1;
        chk("rd_level0", tag_level, 0);
        chk("resp_idle", s_rd_resp_valid, 0);
        // fill the 4-deep tag FIFO from port1
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle();
            drive(1, 1'b0, 1'b1, 1'b1);
            #1;
            chk("fill_grant", s_cmd_ready, 4'b0010);
        end
        @(negedge clk);
        #1;
        chk("full_level", tag_level, 4);
        chk("full_stall", s_cmd_ready, 0);
        chk("full_rd_en", m_cmd_rd_en, 0);
        @(negedge clk);
        drive(3, 1'b1, 1'b0, 1'b1);
        #1;
        chk("full_wr_grant", s_cmd_ready, 4'b1000);
        chk("full_wr_en", m_cmd_wr_en, 1);
        @(negedge clk);
        idle();
        drive(1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("wr_rd_as_wr", s_cmd_ready, 4'b0010);
        chk("wr_rd_wr_en", m_cmd_wr_en, 1);
        chk("wr_rd_rd_en", m_cmd_rd_en, 0);
        // reset, then a response with no outstanding tag
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rd_resp_valid = 1'b1;
        #1;
        chk("post_rst_level", tag_level, 0);
        chk("uflow_ready", m_rd_resp_ready, 0);
        chk("uflow_valid", s_rd_resp_valid, 0);
        @(negedge clk);
        m_rd_resp_valid = 1'b0;
        #1;
        chk("uflow_set", resp_underflow, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("uflow_sticky", resp_underflow, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int p = 0; p < P; p++) drive(p, 1'b1, 1'b0, 1'b1);
        #1;
        chk("rst_force_ready", s_cmd_ready, 0);
        chk("rst_force_wr_en", m_cmd_wr_en, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        drive(1, 1'b1, 1'b0, 1'b1);
        drive(3, 1'b1, 1'b0, 1'b1);
        #1;
        chk("uflow_cleared", resp_underflow, 0);
        chk("rst_ptr", s_cmd_ready, 4'b0010);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
